// File: rtl/radar_tx_strobe_sink_if.sv
// ---------------------------------------------------------------------------
// radar_tx_strobe_sink_if
//   AXI-Stream style sample link from the radar delay FIFO to the TX strobe
//   sink.
//   i_tdata  : sample (I/Q packed)
//   i_tvalid : sample present
//   i_tlast  : last sample of the packet
//   i_tready : sink accepts the sample this cycle
//   master : FIFO side (drives data/valid/last)
//   slave  : sink side (drives ready)
// ---------------------------------------------------------------------------
interface radar_tx_strobe_sink_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tvalid;
  logic             i_tlast;
  logic             i_tready;

  modport master (output i_tdata, output i_tvalid, output i_tlast, input i_tready);
  modport slave  (input i_tdata, input i_tvalid, input i_tlast, output i_tready);
endinterface

// File: rtl/radar_tx_strobe_sink.sv
// ---------------------------------------------------------------------------
// radar_tx_strobe_sink
//   Drains one burst of burst_len samples from the delay FIFO into the radio
//   frontend, one sample per frontend strobe. Underruns (strobe with no sample)
//   and tlast/length mismatches are flagged, after which the rest of the packet
//   is discarded up to its tlast.
//
//   clk, reset_n   : clock, asynchronous active-low reset
//   clear          : synchronous soft reset, overrides every other input
//   start          : arm a burst of burst_len samples (ignored unless idle)
//   burst_len      : samples per burst, latched when start is accepted
//   s_axis         : sample stream from the FIFO (slave modport)
//   strobe         : frontend sample enable
//   tx_data/tx_stb : sample to the frontend, tx_stb marks a new sample
//   run            : burst armed or running
//   done           : clean burst completion pulse
//   err_underrun   : strobe arrived with no sample available
//   err_len        : tlast did not line up with burst_len
//   underrun_cnt   : saturating underrun count
// ---------------------------------------------------------------------------
module radar_tx_strobe_sink #(
  parameter int WIDTH    = 32,
  parameter int LEN_W    = 16,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                start,
  input  logic [LEN_W-1:0]    burst_len,
  radar_tx_strobe_sink_if.slave s_axis,
  input  logic                strobe,
  output logic [WIDTH-1:0]    tx_data,
  output logic                tx_stb,
  output logic                run,
  output logic                done,
  output logic                err_underrun,
  output logic                err_len,
  output logic [ERRCNT_W-1:0] underrun_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_next;
  logic             last_beat;
  logic             tready_c;

  assign cnt_next  = cnt_q + LEN_W'(1);
  assign last_beat = (cnt_next == len_q);

  // Ready follows the strobe while running so exactly one beat is pulled per
  // strobe; clear blocks it so an abandoned burst consumes nothing upstream.
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    tready_c = 1'b0;
    case (state)
      RUN:     tready_c = strobe;
      FLUSH:   tready_c = 1'b1;
      default: tready_c = 1'b0;
    endcase
    if (clear) tready_c = 1'b0;
  end

  assign s_axis.i_tready = tready_c;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      tx_data      <= '0;
      tx_stb       <= 1'b0;
      run          <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      err_len      <= 1'b0;
      underrun_cnt <= '0;
    end else if (clear) begin
      state        <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      tx_data      <= '0;
      tx_stb       <= 1'b0;
      run          <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      err_len      <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      // Pulses default low; tx_data holds unless a strobe is serviced.
      tx_stb       <= 1'b0;
      done         <= 1'b0;
      err_underrun <= 1'b0;
      err_len      <= 1'b0;

      case (state)
        IDLE: begin
          if (start && (burst_len != '0)) begin
            len_q <= burst_len;
            cnt_q <= '0;
            state <= ARMED;
            run   <= 1'b1;
          end
        end

        // Wait for the FIFO to hold data before honouring strobes.
        ARMED: begin
          if (s_axis.i_tvalid) state <= RUN;
        end

        RUN: begin
          if (strobe) begin
            tx_stb <= 1'b1;
            if (s_axis.i_tvalid) begin
              tx_data <= s_axis.i_tdata;
              cnt_q   <= cnt_next;
              if (last_beat) begin
                run <= 1'b0;
                if (s_axis.i_tlast) begin
                  done  <= 1'b1;
                  state <= IDLE;
                end else begin
                  // Packet is longer than the burst: drop the tail.
                  err_len <= 1'b1;
                  state   <= FLUSH;
                end
              end else if (s_axis.i_tlast) begin
                // Packet ended early: already at a packet boundary.
                err_len <= 1'b1;
                run     <= 1'b0;
                state   <= IDLE;
              end
            end else begin
              tx_data      <= '0;
              err_underrun <= 1'b1;
              run          <= 1'b0;
              state        <= FLUSH;
              if (underrun_cnt != {ERRCNT_W{1'b1}})
                underrun_cnt <= underrun_cnt + ERRCNT_W'(1);
            end
          end
        end

        // Discard beats until the packet boundary.
        FLUSH: begin
          if (s_axis.i_tvalid && s_axis.i_tlast) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radar_tx_strobe_sink.sv
// ---------------------------------------------------------------------------
// tb_radar_tx_strobe_sink
//   Self-checking bench for radar_tx_strobe_sink. Each burst is described by
//   (burst length, packet length, underrun position); a reference model turns
//   that into the list of frontend events expected, which a separate monitor
//   matches against every tx_stb / flag pulse the DUT produces.
// ---------------------------------------------------------------------------
module tb_radar_tx_strobe_sink;

  localparam int WIDTH    = 32;
  localparam int LEN_W    = 16;
  localparam int ERRCNT_W = 2;
  localparam int UCNT_MAX = (1 << ERRCNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                clear = 1'b0;
  logic                start = 1'b0;
  logic [LEN_W-1:0]    burst_len = '0;
  logic                strobe = 1'b0;
  logic [WIDTH-1:0]    tx_data;
  logic                tx_stb;
  logic                run;
  logic                done;
  logic                err_underrun;
  logic                err_len;
  logic [ERRCNT_W-1:0] underrun_cnt;

  radar_tx_strobe_sink_if #(.WIDTH(WIDTH)) bus ();

  radar_tx_strobe_sink #(
    .WIDTH   (WIDTH),
    .LEN_W   (LEN_W),
    .ERRCNT_W(ERRCNT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .start       (start),
    .burst_len   (burst_len),
    .s_axis      (bus.slave),
    .strobe      (strobe),
    .tx_data     (tx_data),
    .tx_stb      (tx_stb),
    .run         (run),
    .done        (done),
    .err_underrun(err_underrun),
    .err_len     (err_len),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             done;
    logic             eu;
    logic             el;
    int               ucnt;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               vectors = 0;
  int               miscompares = 0;
  int               ucnt_model = 0;
  int               cyc = 0;
  logic [WIDTH-1:0] beat_d [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [WIDTH-1:0] data, input logic dn,
                                   input logic eu, input logic el);
    exp_t e;
    e.data = data; e.done = dn; e.eu = eu; e.el = el; e.ucnt = ucnt_model;
    exp_q.push_back(e);
  endfunction

  // Reference model: what the frontend sees for one burst of burst length L,
  // a packet of P beats (tlast on the last) and an upstream stall before
  // beat u (u = 0 means no stall).
  function automatic void model_burst(input int L, input int P, input int u);
    int n;
    n = (L < P) ? L : P;
    if (u != 0 && u < n) begin
      for (int i = 0; i < u; i++) push_exp(beat_d[i], 1'b0, 1'b0, 1'b0);
      if (ucnt_model < UCNT_MAX) ucnt_model++;
      push_exp('0, 1'b0, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < n - 1; i++) push_exp(beat_d[i], 1'b0, 1'b0, 1'b0);
      push_exp(beat_d[n-1], (P == L), 1'b0, (P != L));
    end
  endfunction

  function automatic logic strobe_pat(input int period);
    if (period == 0) return 1'($urandom_range(0, 1));
    return (cyc % period) == 0;
  endfunction

  // Monitor: every strobe or flag pulse must match the next expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && (tx_stb || done || err_underrun || err_len)) begin
        check("event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("tx_stb", tx_stb, 1);
          check("tx_data", tx_data, mon_e.data);
          check("done/err_underrun/err_len", {done, err_underrun, err_len},
                {mon_e.done, mon_e.eu, mon_e.el});
          check("underrun_cnt", underrun_cnt, mon_e.ucnt);
        end
      end
    end
  end

  // Drive one burst. abort_at >= 0 stops feeding after that many accepted
  // beats (the caller then abandons the burst) and only those are expected.
  task automatic run_burst(input int L, input int P, input int u, input int period,
                           input int abort_at = -1);
    int k, budget;
    bit ud;
    for (int i = 0; i < 8; i++) beat_d[i] = $urandom() | 32'h1;
    if (abort_at >= 0) begin
      for (int i = 0; i < abort_at; i++) push_exp(beat_d[i], 1'b0, 1'b0, 1'b0);
    end else begin
      model_burst(L, P, u);
    end
    @(negedge clk);
    start = 1'b1; burst_len = LEN_W'(L);
    bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0; strobe = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("run_after_start", run, 1);
    k = 0; budget = 300; ud = 1'b0;
    while (k < P && k != abort_at && budget > 0) begin
      cyc++; budget--;
      if (!ud && u != 0 && k == u) begin
        bus.i_tvalid = 1'b0; strobe = 1'b1; ud = 1'b1;
      end else begin
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = beat_d[k];
        bus.i_tlast  = (k == P - 1);
        strobe       = strobe_pat(period);
      end
      #4;
      if (bus.i_tready && bus.i_tvalid) k++;
      @(negedge clk);
    end
    check("beats_consumed", k, (abort_at >= 0) ? abort_at : P);
    if (abort_at < 0) begin
      bus.i_tvalid = 1'b0; bus.i_tlast = 1'b0; strobe = 1'b0;
      repeat (2) @(negedge clk);
      check("run_after_burst", run, 0);
      strobe = 1'b1;
      #1;
      check("tready_idle", bus.i_tready, 0);
      @(negedge clk);
      strobe = 1'b0;
      check("events_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    int L, P, u, n;
    bus.i_tdata = '0; bus.i_tvalid = 1'b1; bus.i_tlast = 1'b0; strobe = 1'b1;

    // Reset state.
    #12;
    check("reset_outputs", {tx_data, tx_stb, run, done, err_underrun, err_len, underrun_cnt}, 0);
    check("reset_tready", bus.i_tready, 0);
    @(negedge clk);
    bus.i_tvalid = 1'b0; strobe = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean burst of 4, strobe every third cycle.
    run_burst(4, 4, 0, 3);
    // Upstream stall after two samples: underrun, then C,D flushed.
    run_burst(4, 4, 2, 2);
    // Packet longer than burst: error after beat 3, beats 4,5 dropped.
    run_burst(3, 5, 0, 1);
    // Packet shorter than burst: two samples then error, no done.
    run_burst(6, 2, 0, 0);

    // Zero-length start is ignored.
    @(negedge clk);
    start = 1'b1; burst_len = '0;
    @(negedge clk);
    start = 1'b0;
    check("zero_len_run", run, 0);
    strobe = 1'b1; bus.i_tvalid = 1'b1; bus.i_tlast = 1'b0;
    #4;
    check("zero_len_tready", bus.i_tready, 0);
    @(negedge clk);
    bus.i_tvalid = 1'b0; strobe = 1'b0;

    // Clear mid-RUN: two samples out, then the burst is abandoned.
    run_burst(4, 4, 0, 1, 2);
    clear = 1'b1; strobe = 1'b1; bus.i_tvalid = 1'b1; bus.i_tdata = beat_d[2];
    #4;
    check("tready_during_clear", bus.i_tready, 0);
    @(negedge clk);
    clear = 1'b0; bus.i_tvalid = 1'b0; strobe = 1'b1;
    ucnt_model = 0;
    check("clear_outputs", {tx_data, tx_stb, run, done, err_underrun, err_len, underrun_cnt}, 0);
    #1;
    check("clear_tready", bus.i_tready, 0);
    @(negedge clk);
    strobe = 1'b0;
    check("clear_events_drained", exp_q.size(), 0);

    // Underrun counter saturation (ERRCNT_W = 2).
    repeat (5) run_burst(3, 3, 1, 1);
    check("underrun_cnt_saturated", underrun_cnt, UCNT_MAX);

    // Randomized bursts.
    for (int b = 0; b < 40; b++) begin
      L = $urandom_range(1, 6);
      P = $urandom_range(1, 8);
      n = (L < P) ? L : P;
      u = (n >= 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
      run_burst(L, P, u, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
